// File: rtl/controlador_sequenciador.sv
// SAP-1 controller/sequencer: six-state one-hot ring (T1..T6) stepped on the
// falling clock edge, decoding the IR opcode nibble into the 12-bit control word.
module controlador_sequenciador #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic        clk,
  input  logic        n_clr,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  t,
  output logic        hlt
);

  // Control word bit order: {Cp,Ep,n_Lm,n_CE,n_Li,n_Ei,n_La,Ea,Su,Eu,n_Lb,n_Lo}
  localparam logic [11:0] CON_IDLE   = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_MEM_AD = 12'h1A3;
  localparam logic [11:0] CON_LDA_5  = 12'h2C3;
  localparam logic [11:0] CON_ALU_5  = 12'h2E1;
  localparam logic [11:0] CON_ADD_6  = 12'h3C7;
  localparam logic [11:0] CON_SUB_6  = 12'h3CF;
  localparam logic [11:0] CON_OUT_4  = 12'h3F2;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  logic [5:0] t_q, t_d;
  logic       halt_q, halt_d;
  logic       ring_onehot;

  always_comb begin
    ring_onehot = (t_q != 6'd0) && ((t_q & (t_q - 6'd1)) == 6'd0);
    t_d    = t_q;
    halt_d = halt_q;
    if (!halt_q) begin
      if (!ring_onehot) begin
        t_d = T1;
      end else if ((t_q == T4) && (opcode == OP_HLT)) begin
        // Freeze at T4: the ring does not advance once halted.
        halt_d = 1'b1;
      end else begin
        t_d = {t_q[4:0], t_q[5]};
      end
    end
  end

  always_ff @(negedge clk or negedge n_clr) begin
    if (!n_clr) begin
      t_q    <= T1;
      halt_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      halt_q <= halt_d;
    end
  end

  always_comb begin
    con = CON_IDLE;
    if (n_clr && !halt_q) begin
      case (t_q)
        T1: con = CON_T1;
        T2: con = CON_T2;
        T3: con = CON_T3;
        T4: begin
          if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB))
            con = CON_MEM_AD;
          else if (opcode == OP_OUT)
            con = CON_OUT_4;
        end
        T5: begin
          if (opcode == OP_LDA)
            con = CON_LDA_5;
          else if ((opcode == OP_ADD) || (opcode == OP_SUB))
            con = CON_ALU_5;
        end
        T6: begin
          if (opcode == OP_ADD)
            con = CON_ADD_6;
          else if (opcode == OP_SUB)
            con = CON_SUB_6;
        end
        default: con = CON_IDLE;
      endcase
    end
  end

  assign t   = t_q;
  assign hlt = halt_q | ((t_q == T4) && (opcode == OP_HLT));

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Bench for the SAP-1 sequencer: directed test-plan sequence with literal
// expectations, then randomized opcodes/resets against a step-index model.
module tb_controlador_sequenciador;

  logic        clk = 1'b0;
  logic        n_clr;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t;
  logic        hlt;

  int total = 0;
  int bad   = 0;

  controlador_sequenciador dut (
    .clk    (clk),
    .n_clr  (n_clr),
    .opcode (opcode),
    .con    (con),
    .t      (t),
    .hlt    (hlt)
  );

  always #5 clk = ~clk;

  // Model: step index 0..5 (T1..T6) and a halted flag.
  int m_step   = 0;
  bit m_halted = 1'b0;

  always @(negedge clk or negedge n_clr) begin
    if (!n_clr) begin
      m_step   <= 0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (m_step == 3 && opcode == 4'hF) m_halted <= 1'b1;
      else m_step <= (m_step + 1) % 6;
    end
  end

  function automatic logic [11:0] model_con(int s, logic [3:0] op, bit h, logic rn);
    logic [11:0] ex [0:2];
    if (!rn || h) return 12'h3E3;
    if (s == 0) return 12'h5E3;
    if (s == 1) return 12'hBE3;
    if (s == 2) return 12'h263;
    case (op)
      4'h0: begin ex[0] = 12'h1A3; ex[1] = 12'h2C3; ex[2] = 12'h3E3; end
      4'h1: begin ex[0] = 12'h1A3; ex[1] = 12'h2E1; ex[2] = 12'h3C7; end
      4'h2: begin ex[0] = 12'h1A3; ex[1] = 12'h2E1; ex[2] = 12'h3CF; end
      4'hE: begin ex[0] = 12'h3F2; ex[1] = 12'h3E3; ex[2] = 12'h3E3; end
      default: begin ex[0] = 12'h3E3; ex[1] = 12'h3E3; ex[2] = 12'h3E3; end
    endcase
    return ex[s-3];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  bit model_on = 1'b0;

  always @(posedge clk or negedge clk) begin
    #1;
    if (model_on) begin
      chk("model_t",   {26'd0, t},  32'(6'd1 << m_step));
      chk("model_con", {20'd0, con}, {20'd0, model_con(m_step, opcode, m_halted, n_clr)});
      chk("model_hlt", {31'd0, hlt}, {31'd0, m_halted | (m_step == 3 && opcode == 4'hF && n_clr)});
    end
  end

  task automatic neg1();
    @(negedge clk); #1;
  endtask

  task automatic lit(input string name, input logic [5:0] et, input logic [11:0] ec, input logic eh);
    chk({name, "_t"},   {26'd0, t},   {26'd0, et});
    chk({name, "_con"}, {20'd0, con}, {20'd0, ec});
    chk({name, "_hlt"}, {31'd0, hlt}, {31'd0, eh});
  endtask

  // Starting in T1: step to T3, then check T4..T6 and the wrap to T1.
  task automatic run_instr(input string name, input logic [3:0] op,
                           input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6);
    opcode = op;
    neg1(); neg1();
    neg1(); lit({name, "_T4"}, 6'b001000, c4, 1'b0);
    neg1(); lit({name, "_T5"}, 6'b010000, c5, 1'b0);
    neg1(); lit({name, "_T6"}, 6'b100000, c6, 1'b0);
    neg1(); lit({name, "_wrap"}, 6'b000001, 12'h5E3, 1'b0);
    $display("instr %s op=%b done", name, op);
  endtask

  initial begin
    n_clr  = 1'b0;
    opcode = 4'h0;
    #12;
    model_on = 1'b1;
    lit("reset", 6'b000001, 12'h3E3, 1'b0);
    @(posedge clk); #3;
    n_clr = 1'b1;
    #1 lit("release", 6'b000001, 12'h5E3, 1'b0);
    neg1(); lit("fetch_T2", 6'b000010, 12'hBE3, 1'b0);
    neg1(); lit("fetch_T3", 6'b000100, 12'h263, 1'b0);
    neg1(); lit("lda_T4", 6'b001000, 12'h1A3, 1'b0);
    neg1(); lit("lda_T5", 6'b010000, 12'h2C3, 1'b0);
    neg1(); lit("lda_T6", 6'b100000, 12'h3E3, 1'b0);
    neg1(); lit("lda_wrap", 6'b000001, 12'h5E3, 1'b0);
    $display("instr LDA op=0000 done");

    run_instr("ADD", 4'b0001, 12'h1A3, 12'h2E1, 12'h3C7);
    run_instr("SUB", 4'b0010, 12'h1A3, 12'h2E1, 12'h3CF);
    run_instr("OUT", 4'b1110, 12'h3F2, 12'h3E3, 12'h3E3);
    run_instr("NOP", 4'b0101, 12'h3E3, 12'h3E3, 12'h3E3);

    opcode = 4'b1111;
    neg1(); neg1(); neg1();
    lit("hlt_T4", 6'b001000, 12'h3E3, 1'b1);
    repeat (10) neg1();
    lit("hlt_held", 6'b001000, 12'h3E3, 1'b1);
    opcode = 4'b0000;
    #1 lit("hlt_opchg", 6'b001000, 12'h3E3, 1'b1);
    neg1(); lit("hlt_opchg_edge", 6'b001000, 12'h3E3, 1'b1);
    @(posedge clk); #3;
    n_clr = 1'b0;
    #1 lit("hlt_clr", 6'b000001, 12'h3E3, 1'b0);
    @(posedge clk); #3;
    n_clr = 1'b1;
    $display("instr HLT op=1111 done");

    opcode = 4'b0001;
    neg1(); neg1(); neg1(); neg1();
    lit("add_T5", 6'b010000, 12'h2E1, 1'b0);
    @(posedge clk); #3;
    n_clr = 1'b0;
    #1 lit("async_rst", 6'b000001, 12'h3E3, 1'b0);
    @(posedge clk); #3;
    n_clr = 1'b1;
    #1 lit("async_release", 6'b000001, 12'h5E3, 1'b0);
    $display("instr ADD reset mid-T5 done");

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #3;
      if (m_step == 0 && !m_halted) begin
        case ($urandom_range(0, 6))
          0: opcode = 4'h0;
          1: opcode = 4'h1;
          2: opcode = 4'h2;
          3: opcode = 4'hE;
          4: opcode = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h1;
          default: opcode = 4'($urandom);
        endcase
      end
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
        n_clr = 1'b0;
        @(posedge clk); #3;
        n_clr = 1'b1;
      end
    end

    model_on = 1'b0;
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
